// File: rtl/pe_job_sched.sv
// rtl/pe_job_sched.sv - round-robin two-requester job scheduler in front of a 2x2 pe array
module pe_job_sched #(
    parameter int WIDTH     = 4,
    parameter int CREDITS   = 3,
    parameter int MAX_BEATS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       r0_val,
    output logic                       r0_rdy,
    input  logic [4*WIDTH-1:0]         r0_a,
    input  logic [4*WIDTH-1:0]         r0_b,
    input  logic                       r0_last,
    input  logic                       r1_val,
    output logic                       r1_rdy,
    input  logic [4*WIDTH-1:0]         r1_a,
    input  logic [4*WIDTH-1:0]         r1_b,
    input  logic                       r1_last,
    output logic                       pe_psh,
    output logic [4*WIDTH-1:0]         pe_ain,
    output logic [4*WIDTH-1:0]         pe_bin,
    input  logic [4*(2*WIDTH+1)-1:0]   pe_cout,
    input  logic                       pe_cout_val,
    output logic                       pe_pop,
    output logic                       rsp_val,
    input  logic                       rsp_rdy,
    output logic [4*(2*WIDTH+1)-1:0]   rsp_data,
    output logic                       rsp_id,
    output logic                       rsp_last,
    output logic                       busy,
    output logic                       err
);
    localparam int CNT_W = $clog2(CREDITS + 1);
    localparam int PTR_W = (CREDITS > 1) ? $clog2(CREDITS) : 1;
    localparam int BC_W  = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   outstanding_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic               tag_id_q   [CREDITS];
    logic               tag_last_q [CREDITS];
    logic               err_q;

    logic               own_val, own_last, credit_ok, accept, tag_last;
    logic               fifo_empty, tag_pop, force_end;
    logic [4*WIDTH-1:0] own_a, own_b;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CREDITS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Everything below is viewed through the currently granted requester.
    assign own_val   = owner_q ? r1_val  : r0_val;
    assign own_last  = owner_q ? r1_last : r0_last;
    assign own_a     = owner_q ? r1_a    : r0_a;
    assign own_b     = owner_q ? r1_b    : r0_b;

    // Credit check uses the registered count only, so a pop never frees a slot in the same cycle.
    assign credit_ok = outstanding_q < CNT_W'(CREDITS);
    assign r0_rdy    = (state_q == BURST) && !owner_q && credit_ok;
    assign r1_rdy    = (state_q == BURST) &&  owner_q && credit_ok;
    assign accept    = (state_q == BURST) && own_val && credit_ok;
    assign tag_last  = own_last || (beat_cnt_q == BC_W'(MAX_BEATS - 1));

    // Response side is a pure pass-through; tags come from the FIFO head.
    assign fifo_empty = (outstanding_q == '0);
    assign rsp_val    = pe_cout_val;
    assign rsp_data   = pe_cout;
    assign pe_pop     = pe_cout_val && rsp_rdy;
    assign tag_pop    = pe_pop && !fifo_empty;
    assign rsp_id     = fifo_empty ? 1'b0 : tag_id_q[rd_ptr_q];
    assign rsp_last   = fifo_empty ? 1'b0 : tag_last_q[rd_ptr_q];
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign err        = err_q;

    // Grant arbitration in IDLE and burst length tracking in BURST.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        force_end  = 1'b0;
        case (state_q)
            IDLE: begin
                if (r0_val || r1_val) begin
                    state_d    = BURST;
                    beat_cnt_d = '0;
                    if (r0_val && r1_val) begin
                        owner_d  = rr_ptr_q;
                        rr_ptr_d = !rr_ptr_q;
                    end else begin
                        owner_d  = r1_val;
                    end
                end
            end
            BURST: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (tag_last) begin
                        state_d   = IDLE;
                        force_end = !own_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and arbitration state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // In-flight credit count doubles as tag FIFO occupancy; pops on an empty FIFO are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            if (accept && !tag_pop) begin
                outstanding_q <= outstanding_q + 1'b1;
            end else if (!accept && tag_pop) begin
                outstanding_q <= outstanding_q - 1'b1;
            end
            if (accept) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (tag_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Tag storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_id_q[wr_ptr_q]   <= owner_q;
            tag_last_q[wr_ptr_q] <= tag_last;
        end
    end

    // Registered push into the array; lanes hold their last value between pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_psh <= 1'b0;
            pe_ain <= '0;
            pe_bin <= '0;
        end else begin
            pe_psh <= accept;
            if (accept) begin
                pe_ain <= own_a;
                pe_bin <= own_b;
            end
        end
    end

    // Sticky error: a job cut short at MAX_BEATS, or a result with no tag to own it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (force_end || (pe_cout_val && fifo_empty)) begin
            err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pe_job_sched.sv
// tb/tb_pe_job_sched.sv - self-checking bench for pe_job_sched with array model and scoreboard
module tb_pe_job_sched;
    localparam int W   = 4;
    localparam int CR  = 3;
    localparam int MB  = 8;
    localparam int LAT = 4;
    localparam int LW  = 4 * W;
    localparam int DW  = 4 * (2 * W + 1);

    typedef struct { logic [LW-1:0] a; logic [LW-1:0] b; logic last; } beat_t;
    typedef struct { logic [LW-1:0] a; logic [LW-1:0] b; int due; } arr_t;
    typedef struct { logic id; logic last; logic [DW-1:0] data; } rsp_t;
    typedef struct { logic id; logic [LW-1:0] a; logic [LW-1:0] b; logic [DW-1:0] exp_data; } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic r0_val, r0_rdy, r0_last, r1_val, r1_rdy, r1_last;
    logic [LW-1:0] r0_a, r0_b, r1_a, r1_b, pe_ain, pe_bin;
    logic pe_psh, pe_cout_val, pe_pop, rsp_val, rsp_rdy, rsp_id, rsp_last, busy, err;
    logic [DW-1:0] pe_cout, rsp_data;
    logic arr_val, spur;

    assign pe_cout_val = arr_val | spur;

    pe_job_sched #(.WIDTH(W), .CREDITS(CR), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst(rst),
        .r0_val(r0_val), .r0_rdy(r0_rdy), .r0_a(r0_a), .r0_b(r0_b), .r0_last(r0_last),
        .r1_val(r1_val), .r1_rdy(r1_rdy), .r1_a(r1_a), .r1_b(r1_b), .r1_last(r1_last),
        .pe_psh(pe_psh), .pe_ain(pe_ain), .pe_bin(pe_bin),
        .pe_cout(pe_cout), .pe_cout_val(pe_cout_val), .pe_pop(pe_pop),
        .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_last(rsp_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int    n_tests = 0, n_fail = 0, cyc = 0;
    beat_t rq0[$], rq1[$], exp_push[$];
    arr_t  arr_q[$];
    rsp_t  exp_rsp[$], last_obs;
    int    acc_log[$];
    logic  en0, en1, pend_psh;
    int    exp_out, idx0, idx1, n_acc, n_rsp, n_rsp_last, last_at, gen_beats;
    vec_t  tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input logic [LW-1:0] a, input logic [LW-1:0] b, input logic last);
        beat_t t;
        t.a = a; t.b = b; t.last = last;
        return t;
    endfunction

    // Array model output: lane i carries {0, a_i, b_i}.
    function automatic logic [DW-1:0] cout_of(input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*(2*W+1) +: 2*W+1] = {1'b0, a[i*W +: W], b[i*W +: W]};
        return r;
    endfunction

    task automatic drive_reqs();
        r0_val = en0 && (rq0.size() > 0);
        r1_val = en1 && (rq1.size() > 0);
        if (rq0.size() > 0) {r0_a, r0_b, r0_last} = {rq0[0].a, rq0[0].b, rq0[0].last};
        else                {r0_a, r0_b, r0_last} = '0;
        if (rq1.size() > 0) {r1_a, r1_b, r1_last} = {rq1[0].a, rq1[0].b, rq1[0].last};
        else                {r1_a, r1_b, r1_last} = '0;
    endtask

    task automatic clear_model();
        rq0.delete(); rq1.delete(); exp_push.delete(); arr_q.delete(); exp_rsp.delete(); acc_log.delete();
        en0 = 1; en1 = 1; rsp_rdy = 0; spur = 0; arr_val = 0; pe_cout = '0; pend_psh = 0;
        exp_out = 0; idx0 = 0; idx1 = 0; n_acc = 0; n_rsp = 0; n_rsp_last = 0; last_at = 0; gen_beats = 0;
        last_obs.id = 0; last_obs.last = 0; last_obs.data = '0;
        drive_reqs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_model();
        @(posedge clk);
        #1 rst = 0;
    endtask

    // One clock: sample before the edge, then advance requesters, array model and scoreboard.
    task automatic tick();
        logic a0, a1, pop, psh, tl, dec;
        logic [LW-1:0] ain, bin;
        beat_t bt;
        rsp_t obs, ex;
        int idx;
        @(negedge clk);
        a0 = r0_val && r0_rdy; a1 = r1_val && r1_rdy;
        pop = pe_pop; psh = pe_psh; ain = pe_ain; bin = pe_bin;
        obs.id = rsp_id; obs.last = rsp_last; obs.data = rsp_data;
        chk("psh_latency", psh, pend_psh);
        if (r0_rdy || r1_rdy) begin
            chk("rdy_exclusive", r0_rdy && r1_rdy, 0);
            chk("rdy_credit", exp_out < CR, 1);
        end
        if (psh && exp_push.size() > 0) begin
            bt = exp_push.pop_front();
            chk("push_a", ain, bt.a);
            chk("push_b", bin, bt.b);
        end
        if (pop) begin
            n_rsp++;
            last_obs = obs;
            if (obs.last) begin n_rsp_last++; last_at = n_rsp; end
            if (exp_rsp.size() > 0) begin
                ex = exp_rsp.pop_front();
                chk("rsp_id", obs.id, ex.id);
                chk("rsp_last", obs.last, ex.last);
                chk("rsp_data", obs.data, ex.data);
            end else begin
                chk("spur_id", obs.id, 0);
                chk("spur_last", obs.last, 0);
            end
        end
        dec = pop && (exp_out > 0);
        @(posedge clk);
        #1;
        cyc++;
        if (psh) arr_q.push_back('{a: ain, b: bin, due: cyc + LAT - 1});
        if (pop && arr_val) void'(arr_q.pop_front());
        if (dec) exp_out--;
        if (a0 || a1) begin
            n_acc++;
            acc_log.push_back(a1 ? 1 : 0);
            bt  = a1 ? rq1.pop_front() : rq0.pop_front();
            idx = a1 ? idx1 : idx0;
            tl  = bt.last || (idx == MB - 1);
            idx = tl ? 0 : idx + 1;
            if (a1) idx1 = idx; else idx0 = idx;
            exp_push.push_back(bt);
            ex.id = a1; ex.last = tl; ex.data = cout_of(bt.a, bt.b);
            exp_rsp.push_back(ex);
            exp_out++;
        end
        pend_psh = a0 || a1;
        arr_val  = (arr_q.size() > 0) && (arr_q[0].due <= cyc);
        pe_cout  = (arr_q.size() > 0) ? cout_of(arr_q[0].a, arr_q[0].b) : '0;
        drive_reqs();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        en0 = 1; en1 = 1; rsp_rdy = 1;
        drive_reqs();
        while ((exp_rsp.size() > 0 || rq0.size() > 0 || rq1.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, (exp_rsp.size() > 0 || rq0.size() > 0 || rq1.size() > 0), 0);
        tick();
        #1;
    endtask

    task automatic gen_job(input int who);
        int len;
        len = $urandom_range(1, MB);
        for (int j = 0; j < len; j++) begin
            if (who == 1) rq1.push_back(mk_beat(LW'($urandom), LW'($urandom), j == len - 1));
            else          rq0.push_back(mk_beat(LW'($urandom), LW'($urandom), j == len - 1));
        end
        gen_beats += len;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1;
        clear_model();
        tbl[0] = '{id: 1'b0, a: 16'h1234, b: 16'h5678, exp_data: {9'h015, 9'h026, 9'h037, 9'h048}};
        tbl[1] = '{id: 1'b1, a: 16'hFFFF, b: 16'h0000, exp_data: {9'h0F0, 9'h0F0, 9'h0F0, 9'h0F0}};
        tbl[2] = '{id: 1'b0, a: 16'h0000, b: 16'hFFFF, exp_data: {9'h00F, 9'h00F, 9'h00F, 9'h00F}};
        tbl[3] = '{id: 1'b1, a: 16'hA5C3, b: 16'h3C5A, exp_data: {9'h0A3, 9'h05C, 9'h0C5, 9'h03A}};

        // Reset state
        do_reset();
        #1;
        chk("rst_r0_rdy", r0_rdy, 0); chk("rst_r1_rdy", r1_rdy, 0);
        chk("rst_psh", pe_psh, 0); chk("rst_ain", pe_ain, 0); chk("rst_bin", pe_bin, 0);
        chk("rst_busy", busy, 0); chk("rst_err", err, 0);

        // Single 2-beat job from r0
        do_reset();
        rsp_rdy = 1;
        rq0.push_back(mk_beat(16'h1111, 16'h2222, 1'b0));
        rq0.push_back(mk_beat(16'h3333, 16'h4444, 1'b1));
        drive_reqs();
        #1 chk("t1_rdy_c0", r0_rdy, 0);
        tick(); #1 chk("t1_rdy_c1", r0_rdy, 1);
        tick(); #1 chk("t1_psh_c2", pe_psh, 1);
        tick(); #1 chk("t1_psh_c3", pe_psh, 1);
        drain("t1", 40);
        chk("t1_nrsp", n_rsp, 2); chk("t1_nlast", n_rsp_last, 1); chk("t1_last_pos", last_at, 2);
        chk("t1_id", last_obs.id, 0); chk("t1_busy", busy, 0); chk("t1_err", err, 0);

        // Table of isolated single-beat jobs with hand-computed results
        for (int i = 0; i < 4; i++) begin
            do_reset();
            if (tbl[i].id) rq1.push_back(mk_beat(tbl[i].a, tbl[i].b, 1'b1));
            else           rq0.push_back(mk_beat(tbl[i].a, tbl[i].b, 1'b1));
            drain("tbl", 40);
            chk("tbl_data", last_obs.data, tbl[i].exp_data);
            chk("tbl_id", last_obs.id, tbl[i].id);
            chk("tbl_last", last_obs.last, 1);
            chk("tbl_busy", busy, 0);
            chk("tbl_err", err, 0);
        end

        // Credit stall with responses held off
        do_reset();
        for (int j = 0; j < 5; j++) rq0.push_back(mk_beat(LW'($urandom), LW'($urandom), j == 4));
        drive_reqs();
        repeat (12) tick();
        #1;
        chk("t2_acc_stall", n_acc, 3); chk("t2_rdy_low", r0_rdy, 0); chk("t2_rsp_val", rsp_val, 1);
        rsp_rdy = 1;
        #1 chk("t2_pop", pe_pop, 1);
        tick();
        rsp_rdy = 0;
        #1 chk("t2_rdy_back", r0_rdy, 1);
        drain("t2", 60);
        chk("t2_nrsp", n_rsp, 5); chk("t2_last_pos", last_at, 5);
        chk("t2_busy", busy, 0); chk("t2_err", err, 0);

        // Contention: both requesters, four 1-beat jobs each
        do_reset();
        for (int j = 0; j < 4; j++) begin
            rq0.push_back(mk_beat(LW'($urandom), LW'($urandom), 1'b1));
            rq1.push_back(mk_beat(LW'($urandom), LW'($urandom), 1'b1));
        end
        drain("t3", 200);
        chk("t3_nacc", n_acc, 8);
        for (int j = 0; j < acc_log.size() && j < 8; j++) chk("t3_grant", acc_log[j], j % 2);
        chk("t3_busy", busy, 0); chk("t3_err", err, 0);

        // Forced termination: 10 beats from r1, last never set
        do_reset();
        for (int j = 0; j < 10; j++) rq1.push_back(mk_beat(LW'($urandom), LW'($urandom), 1'b0));
        drain("t4", 200);
        chk("t4_nacc", n_acc, 10); chk("t4_nrsp", n_rsp, 10);
        chk("t4_nlast", n_rsp_last, 1); chk("t4_last_pos", last_at, 8);
        chk("t4_err", err, 1); chk("t4_busy_new_job", busy, 1);

        // Spurious result with nothing pushed
        do_reset();
        rsp_rdy = 1;
        spur = 1;
        #1;
        chk("t5_pop", pe_pop, 1); chk("t5_val", rsp_val, 1);
        chk("t5_id", rsp_id, 0); chk("t5_last", rsp_last, 0);
        tick();
        spur = 0;
        #1;
        chk("t5_err", err, 1); chk("t5_busy", busy, 0);

        // Asynchronous reset in the middle of a 4-beat burst
        do_reset();
        rsp_rdy = 1;
        for (int j = 0; j < 4; j++) rq0.push_back(mk_beat(LW'($urandom), LW'($urandom), j == 3));
        drive_reqs();
        n = 0;
        while (n_acc < 2 && n < 20) begin tick(); n++; end
        chk("t6_two_acc", n_acc, 2);
        #2 rst = 1;
        clear_model();
        #1;
        chk("t6_psh", pe_psh, 0); chk("t6_r0_rdy", r0_rdy, 0); chk("t6_r1_rdy", r1_rdy, 0);
        chk("t6_busy", busy, 0); chk("t6_err", err, 0);
        rst = 0;
        rq1.push_back(mk_beat(16'hBEEF, 16'hCAFE, 1'b0));
        rq1.push_back(mk_beat(16'h0F0F, 16'hF0F0, 1'b1));
        drain("t6", 60);
        chk("t6_nrsp", n_rsp, 2); chk("t6_id", last_obs.id, 1); chk("t6_last_pos", last_at, 2);
        chk("t6_busy_after", busy, 0); chk("t6_err_after", err, 0);

        // Randomized traffic against the scoreboard
        do_reset();
        for (int i = 0; i < 800; i++) begin
            en0 = $urandom_range(0, 4) != 0;
            en1 = $urandom_range(0, 4) != 0;
            rsp_rdy = $urandom_range(0, 3) != 0;
            if (rq0.size() == 0 && $urandom_range(0, 5) == 0 && gen_beats < 300) gen_job(0);
            if (rq1.size() == 0 && $urandom_range(0, 5) == 0 && gen_beats < 300) gen_job(1);
            drive_reqs();
            tick();
        end
        drain("rnd", 500);
        chk("rnd_nacc", n_acc, gen_beats); chk("rnd_nrsp", n_rsp, gen_beats);
        chk("rnd_err", err, 0); chk("rnd_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_job_sched.md
Name: pe_job_sched

Overview:
Round-robin job scheduler that shares one 2x2 pe array between two requesters. Accepts bursts of operand beats (one beat = four a-lanes + four b-lanes) from the granted requester and pushes them into the array. It enforces a credit limit on in-flight beats and routes each popped cout beat back to its owning requester with id/last tags. Sits directly above the pe wrapper.

Parameters:
WIDTH, 4, operand lane width; cout lane width is 2*WIDTH+1
CREDITS, 3, max beats pushed but not yet popped; also the tag FIFO depth
MAX_BEATS, 8, max beats per job before forced termination

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
r0_val  input  1  requester 0 beat valid
r0_rdy  output  1  requester 0 beat accepted when r0_val&r0_rdy
r0_a  input  4*WIDTH  requester 0 a lanes [3:0]
r0_b  input  4*WIDTH  requester 0 b lanes [3:0]
r0_last  input  1  final beat of requester 0 job
r1_val, r1_rdy, r1_a, r1_b, r1_last  as r0_*, requester 1
pe_psh  output  1  push to array
pe_ain  output  4*WIDTH  a lanes to array
pe_bin  output  4*WIDTH  b lanes to array
pe_cout  input  4*(2*WIDTH+1)  array result
pe_cout_val  input  1  array result valid
pe_pop  output  1  pop array result
rsp_val  output  1  response valid
rsp_rdy  input  1  response accepted
rsp_data  output  4*(2*WIDTH+1)  result beat
rsp_id  output  1  owning requester
rsp_last  output  1  last result of that job
busy  output  1  state!=IDLE or outstanding!=0
err  output  1  sticky protocol error

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, outstanding=0, beat_cnt=0, tag FIFO empty. pe_psh=0, pe_ain/pe_bin=0, err=0, busy=0. All rdy=0.
- FSM IDLE: if any rN_val, grant one requester:
  - only one valid: grant it;
  - both valid: grant rr_ptr, then set rr_ptr to the other id.
  - Latch owner, beat_cnt=0, go BURST. No beat is accepted in IDLE, so the first beat is accepted one cycle after val at the earliest.
- FSM BURST: owner rdy = (outstanding < CREDITS). Non-owner rdy=0.
  - Accept = owner val & rdy. On accept, push {owner, tag_last} into the tag FIFO, increment beat_cnt, and register the lanes.
  - tag_last = rN_last | (beat_cnt==MAX_BEATS-1).
  - If tag_last: go IDLE. If rN_last was 0 (forced termination), set err.
- Push path: pe_psh, pe_ain and pe_bin are registered. Latency from accept to pe_psh is 1 cycle. pe_psh=0 with lanes held on non-accept cycles.
- Credits:
  - outstanding +1 on accept, -1 on pe_pop; both in the same cycle leaves it unchanged.
  - No same-cycle credit bypass: rdy uses the registered count.
  - Never exceeds CREDITS.
- Response path (combinational):
  - rsp_val = pe_cout_val; rsp_data = pe_cout.
  - rsp_id and rsp_last come from the tag FIFO head.
  - pe_pop = rsp_val & rsp_rdy. The tag FIFO pops on pe_pop.
  - rsp_val held with rsp_rdy=0: array output and tags are stable; no pop.
- Tag FIFO: CREDITS deep with wrap-around pointers. Push and pop in the same cycle are allowed at any occupancy. It cannot overflow because it is credit-bounded.
- pe_cout_val while the tag FIFO is empty: set err, rsp_id=0, rsp_last=0, still pop. Counters saturate at 0.
- Jobs may overlap: a new grant may occur while an earlier job's results drain. Responses are returned in push order.
- rst mid-burst: everything clears immediately. Beats already inside the array are not tracked after reset.
- err is sticky until rst.

Test Plan:
- Single job, r0, 2 beats, rsp_rdy=1:
  - r0_val at cycle 0, r0_rdy at cycle 1, pe_psh at cycles 2-3.
  - Model returns cout 4 cycles after each push.
  - Expect rsp_id=0 on 2 beats, rsp_last only on beat 2, busy=0 afterwards, err=0.
- Credit stall, CREDITS=3, 5-beat job, rsp_rdy=0:
  - r0_rdy drops after 3 accepts; outstanding=3.
  - Raising rsp_rdy pops one beat and r0_rdy reasserts the next cycle.
  - All 5 results come back in order.
- Contention: r0 and r1 both valid from reset, each sending a 1-beat job, repeated 4 times.
  - Grants alternate 0,1,0,1…; rsp_id sequence matches; no starvation.
- Forced termination, MAX_BEATS=8: r1 sends 10 beats with last never set.
  - Grant ends after beat 8 with rsp_last on result 8 and err=1.
  - Beats 9-10 are taken as a new job.
- Spurious result: pe_cout_val=1 with no beats pushed.
  - Expect pe_pop=1 (with rsp_rdy=1), rsp_id=0, err=1, outstanding stays 0.
- Reset mid-burst: rst pulsed asynchronously between clock edges after 2 of 4 beats.
  - Immediately: pe_psh=0, rdy=0, busy=0, err=0.
  - A new r1 job then proceeds normally.
